mem_lsu: RTL
============

Name: mem_lsu

Overview:
- Memory-access pipeline stage between ex_mem and mem_wb.
- Passes register and CSR write-back fields through to mem_wb.
- Runs loads and stores on a req/gnt/rvalid data bus and holds the pipeline via stall_req_o while an access is in flight.
- Aligns and sign/zero-extends load data and positions store data/byte enables.

Parameters:
- ADDR_W, 32, data-bus address width
- DATA_W, 32, register/bus data width (`RDATA_WIDTH)
- RADDR_W, 5, register address width (`RADDR_WIDTH)
- CSR_AW, 12, CSR address width (`CSR_ADDR_WIDTH)

Ports:
- clk_i in 1 clock
- rst_i in 1 reset; synchronous, active-high, sampled on posedge clk_i
- flush_int_i in 1 interrupt flush
- mem_re_i in 1 load request
- mem_we_i in 1 store request
- mem_size_i in 2 access size: 00 byte, 01 half, 10 word
- mem_unsigned_i in 1 load zero-extends when 1
- mem_addr_i in ADDR_W byte address
- mem_wdata_i in DATA_W store data, right-aligned
- reg_waddr_i/reg_we_i/reg_wdata_i in RADDR_W/1/DATA_W write-back from ex_mem
- csr_we_i/csr_waddr_i/csr_wdata_i in 1/CSR_AW/DATA_W CSR write-back
- reg_waddr_o/reg_we_o/reg_wdata_o out RADDR_W/1/DATA_W to mem_wb
- csr_we_o/csr_waddr_o/csr_wdata_o out 1/CSR_AW/DATA_W to mem_wb
- stall_req_o out 1 stall request to the control unit
- bus_req_o out 1 data-bus request
- bus_we_o out 1 write strobe
- bus_addr_o out ADDR_W word-aligned address
- bus_be_o out 4 byte enables
- bus_wdata_o out DATA_W lane-positioned store data
- bus_gnt_i in 1 request accepted
- bus_rvalid_i in 1 read data / store ack valid
- bus_rdata_i in DATA_W read data
- misalign_o out 1 misaligned-access flag (MISALIGN_TRAP_EN only)

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE; state resets to IDLE.
- While rst_i is high, all outputs are 0 and the capture register is cleared.
- IDLE, no memory op: combinational pass-through of all reg_*/csr_* fields; stall_req_o=0, bus_req_o=0.
- IDLE, mem_re_i|mem_we_i: bus_req_o=1, stall_req_o=1 in the same cycle.
  - bus_gnt_i=1 -> WAIT.
  - bus_gnt_i=0 -> REQ.
- REQ: bus_req_o and bus_addr/be/we/wdata held stable until gnt (stable until gnt); then -> WAIT.
- WAIT: stall_req_o=1; on bus_rvalid_i, capture bus_rdata_i -> DONE.
- DONE: stall_req_o=0.
  - Load: reg_we_o=1, reg_wdata_o=extended capture.
  - Store: write-back fields pass through.
  - Next state IDLE.
- Minimum latency (gnt in the same cycle, rvalid next cycle): 3 cycles, with 2 stall cycles.
- Mem-op inputs are ignored outside IDLE; the pipeline is stalled, so inputs are stable.
- Byte enables and data lanes:
  - Byte: bus_be_o=0001<<addr[1:0], data replicated across lanes.
  - Half: bus_be_o=0011<<addr[1:0], data replicated across lanes.
  - Word: bus_be_o=1111.
- Load extract: the selected lane is shifted right, then sign- or zero-extended per mem_unsigned_i.
- mem_re_i and mem_we_i both set: the store wins.
- flush_int_i in IDLE/REQ: drop the request, return to IDLE, drive zero write-back.
- flush_int_i in WAIT: remain in WAIT until rvalid, discard the data, then go to IDLE with no write-back; stall_req_o stays 1.
- rst_i mid-transaction returns to IDLE immediately; the bus is expected to be reset in the same cycle.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Enabled: a half access at addr[0]=1, or a word access at addr[1:0]!=0, sets misalign_o=1 for one cycle in IDLE; no bus request and no stall; reg_we_o=0.
- Disabled: misalign_o is tied 0 and the low address bits are forced to natural alignment (half: addr[0]=0; word: addr[1:0]=0).

Decomposition:
- defines.v holds the widths, MEM_SIZE_* encodings, FSM state encodings, ZERO and WRITE_ENABLE/DISABLE.
- One sub-module, lsu_align: combinational byte-enable/lane positioning for stores and extract/extend for loads.

Test Plan:
- ALU op reg_waddr_i=5, wdata=0x1234, no mem op -> same values out in the same cycle, stall_req_o=0.
- lb at 0x1003, unsigned=0, rdata=0x80AABBCC, gnt immediate, rvalid +1 -> stall for 2 cycles, DONE reg_wdata_o=0xFFFFFF80.
- sh 0xBEEF at 0x2002 -> bus_be_o=1100, bus_wdata_o=0xBEEFBEEF, bus_addr_o=0x2000.
- lw with gnt delayed 3 cycles -> address/req held stable across REQ, 5 stall cycles total.
- flush_int_i during WAIT of lw -> the following rvalid is discarded, reg_we_o=0, FSM back in IDLE.
- MISALIGN_TRAP_EN, lw at 0x3001 -> misalign_o=1, bus_req_o=0; without the macro -> bus_addr_o=0x3000 and the access completes.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu_pkg
//  Purpose  : Shared widths, access-size encodings, write-enable constants,
//             FSM state type and alignment helper for the mem_lsu stage.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam int c_ADDR_W  = 32;
    localparam int c_DATA_W  = 32;
    localparam int c_RADDR_W = 5;
    localparam int c_CSR_AW  = 12;

    localparam logic [1:0] c_MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_MEM_SIZE_WORD = 2'b10;

    localparam logic        c_WRITE_ENABLE  = 1'b1;
    localparam logic        c_WRITE_DISABLE = 1'b0;
    localparam logic [31:0] c_ZERO          = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_t;

    // Halves must sit on even addresses, words on multiples of four.
    // The reserved size code 2'b11 is treated as a word.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic r;
        r = 1'b0;
        if (size == c_MEM_SIZE_HALF)
            r = offset[0];
        else if (size != c_MEM_SIZE_BYTE)
            r = (offset != 2'b00);
        return r;
    endfunction

endpackage : mem_lsu_pkg
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational lane logic for the load/store unit.
//             Stores: byte enables from size/offset, store data replicated
//             across the lanes. Loads: selected lane shifted down and then
//             sign- or zero-extended.
//  Ports    : i_size, i_offset, i_unsigned  - access attributes
//             i_wdata / o_wdata             - right-aligned / lane data
//             o_be                          - byte enables
//             i_rdata / o_rdata             - raw bus word / extended value
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = i_rdata >> {i_offset, 3'b000};
        o_be      = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rdata;
        case (i_size)
            c_MEM_SIZE_BYTE: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'h000000, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            c_MEM_SIZE_HALF: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'h0000, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : Memory-access pipeline stage between ex_mem and mem_wb.
//             Passes register/CSR write-back through, runs loads and stores
//             on a req/gnt/rvalid bus and stalls the pipeline meanwhile.
//  Ports    : clk_i, rst_i (sync, active-high), flush_int_i
//             mem_* from ex_mem      - access request
//             reg_* / csr_* in/out   - write-back fields
//             stall_req_o            - to the control unit
//             bus_*                  - data bus master side
//             misalign_o             - alignment trap flag
//  Options  : `define MISALIGN_TRAP_EN to trap misaligned halves/words
//             instead of silently forcing natural alignment.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int DATA_W  = c_DATA_W,
    parameter int RADDR_W = c_RADDR_W,
    parameter int CSR_AW  = c_CSR_AW
)(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_int_i,
    input  logic               mem_re_i,
    input  logic               mem_we_i,
    input  logic [1:0]         mem_size_i,
    input  logic               mem_unsigned_i,
    input  logic [ADDR_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic               reg_we_i,
    input  logic [DATA_W-1:0]  reg_wdata_i,
    input  logic               csr_we_i,
    input  logic [CSR_AW-1:0]  csr_waddr_i,
    input  logic [DATA_W-1:0]  csr_wdata_i,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic               reg_we_o,
    output logic [DATA_W-1:0]  reg_wdata_o,
    output logic               csr_we_o,
    output logic [CSR_AW-1:0]  csr_waddr_o,
    output logic [DATA_W-1:0]  csr_wdata_o,
    output logic               stall_req_o,
    output logic               bus_req_o,
    output logic               bus_we_o,
    output logic [ADDR_W-1:0]  bus_addr_o,
    output logic [3:0]         bus_be_o,
    output logic [DATA_W-1:0]  bus_wdata_o,
    input  logic               bus_gnt_i,
    input  logic               bus_rvalid_i,
    input  logic [DATA_W-1:0]  bus_rdata_i,
    output logic               misalign_o
);

    lsu_state_t r_state, w_state_nxt;

    // Request attributes captured when the access leaves IDLE, so the bus
    // fields and the load extraction no longer depend on the stage inputs.
    logic              r_store;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_flushed;

    logic              w_memop;
    logic              w_misalign;
    logic              w_start;
    logic [ADDR_W-1:0] w_addr_nat;

    logic              w_req_store;
    logic              w_req_unsigned;
    logic [1:0]        w_req_size;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_req_wdata;

    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_lane_wdata;
    logic [DATA_W-1:0] w_load_data;

    assign w_memop = mem_re_i | mem_we_i;

`ifdef MISALIGN_TRAP_EN
    assign w_addr_nat = mem_addr_i;
    assign w_misalign = w_memop & is_misaligned(mem_size_i, mem_addr_i[1:0]);
`else
    always_comb begin
        w_addr_nat = mem_addr_i;
        if (mem_size_i == c_MEM_SIZE_HALF)
            w_addr_nat[0] = 1'b0;
        else if (mem_size_i != c_MEM_SIZE_BYTE)
            w_addr_nat[1:0] = 2'b00;
    end
    assign w_misalign = 1'b0;
`endif

    // In IDLE the request is launched straight from the inputs so the bus
    // sees it in the same cycle; afterwards the captured copy is used.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_req_store    = mem_we_i;
            w_req_unsigned = mem_unsigned_i;
            w_req_size     = mem_size_i;
            w_req_addr     = w_addr_nat;
            w_req_wdata    = mem_wdata_i;
        end else begin
            w_req_store    = r_store;
            w_req_unsigned = r_unsigned;
            w_req_size     = r_size;
            w_req_addr     = r_addr;
            w_req_wdata    = r_wdata;
        end
    end

    lsu_align u_align (
        .i_size     (w_req_size),
        .i_offset   (w_req_addr[1:0]),
        .i_unsigned (w_req_unsigned),
        .i_wdata    (w_req_wdata),
        .i_rdata    (r_rdata),
        .o_be       (w_be),
        .o_wdata    (w_lane_wdata),
        .o_rdata    (w_load_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= c_MEM_SIZE_BYTE;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_flushed  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_store    <= mem_we_i;
                r_unsigned <= mem_unsigned_i;
                r_size     <= mem_size_i;
                r_addr     <= w_addr_nat;
                r_wdata    <= mem_wdata_i;
            end
            if (r_state == S_WAIT && bus_rvalid_i)
                r_rdata <= bus_rdata_i;
            // Remember an interrupt flush that arrives while the bus still
            // owes us a response; cleared once that response is consumed.
            r_flushed <= (r_state == S_WAIT) && !bus_rvalid_i
                         && (r_flushed || flush_int_i);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        reg_waddr_o = reg_waddr_i;
        reg_we_o    = reg_we_i;
        reg_wdata_o = reg_wdata_i;
        csr_we_o    = csr_we_i;
        csr_waddr_o = csr_waddr_i;
        csr_wdata_o = csr_wdata_i;
        stall_req_o = 1'b0;
        bus_req_o   = 1'b0;
        misalign_o  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (flush_int_i) begin
                    reg_waddr_o = '0;
                    reg_we_o    = c_WRITE_DISABLE;
                    reg_wdata_o = '0;
                    csr_we_o    = c_WRITE_DISABLE;
                    csr_waddr_o = '0;
                    csr_wdata_o = '0;
                end else if (w_misalign) begin
                    misalign_o = 1'b1;
                    reg_we_o   = c_WRITE_DISABLE;
                end else if (w_memop) begin
                    bus_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    reg_we_o    = c_WRITE_DISABLE;
                    csr_we_o    = c_WRITE_DISABLE;
                    w_start     = 1'b1;
                    w_state_nxt = bus_gnt_i ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                if (flush_int_i) begin
                    reg_waddr_o = '0;
                    reg_we_o    = c_WRITE_DISABLE;
                    reg_wdata_o = '0;
                    csr_we_o    = c_WRITE_DISABLE;
                    csr_waddr_o = '0;
                    csr_wdata_o = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    bus_req_o   = 1'b1;
                    stall_req_o = 1'b1;
                    reg_we_o    = c_WRITE_DISABLE;
                    csr_we_o    = c_WRITE_DISABLE;
                    if (bus_gnt_i)
                        w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_req_o = 1'b1;
                reg_we_o    = c_WRITE_DISABLE;
                csr_we_o    = c_WRITE_DISABLE;
                if (bus_rvalid_i)
                    w_state_nxt = (r_flushed || flush_int_i) ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                if (flush_int_i) begin
                    reg_waddr_o = '0;
                    reg_we_o    = c_WRITE_DISABLE;
                    reg_wdata_o = '0;
                    csr_we_o    = c_WRITE_DISABLE;
                    csr_waddr_o = '0;
                    csr_wdata_o = '0;
                end else if (!r_store) begin
                    reg_we_o    = c_WRITE_ENABLE;
                    reg_wdata_o = w_load_data;
                end
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Bus fields are only meaningful alongside a request.
        if (bus_req_o) begin
            bus_we_o    = w_req_store;
            bus_addr_o  = {w_req_addr[ADDR_W-1:2], 2'b00};
            bus_be_o    = w_be;
            bus_wdata_o = w_lane_wdata;
        end else begin
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_be_o    = 4'b0000;
            bus_wdata_o = '0;
        end

        if (rst_i) begin
            reg_waddr_o = '0;
            reg_we_o    = 1'b0;
            reg_wdata_o = '0;
            csr_we_o    = 1'b0;
            csr_waddr_o = '0;
            csr_wdata_o = '0;
            stall_req_o = 1'b0;
            bus_req_o   = 1'b0;
            bus_we_o    = 1'b0;
            bus_addr_o  = '0;
            bus_be_o    = 4'b0000;
            bus_wdata_o = '0;
            misalign_o  = 1'b0;
        end
    end

endmodule : mem_lsu
`default_nettype wire
